mem_port_arbiter: RTL and testbench

- Arbitrates the single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the memory bus.
- Sequences each access through a small FSM with registered request outputs and a one-cycle acknowledge pulse per requester.
- Emits stall_if and stall_d to the hazard/forwarding controller so the pipeline freezes while an access is outstanding.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_d,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              abort_q, abort_d;

  logic              if_req_m;
  logic              d_req_m;
  logic              starve_full;
  logic [31:0]       if_slice;

  // A requester still holding req during its own ack cycle must not be re-granted.
  assign if_req_m    = if_req & ~if_ack_q;
  assign d_req_m     = d_req & ~d_ack_q;
  assign starve_full = (starve_q == CNT_W'(STARVE_MAX));
  assign if_slice    = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    abort_d     = abort_q;

    case (state_q)
      IDLE: begin
        if (if_req_m && (!d_req_m || starve_full)) begin
          state_d    = GNT_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = '0;
          abort_d    = 1'b0;
        end else if (d_req_m) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req_m) begin
            starve_d = '0;
          end else if (!starve_full) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end

      GNT_IF: begin
        if (if_abort) begin
          abort_d = 1'b1;
        end
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_ack_d   = ~(abort_q | if_abort);
          if_rdata_d = if_slice;
        end
      end

      GNT_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      starve_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
      abort_q     <= abort_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_d   = d_req & ~d_ack_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus
// hand-written sequences for priority, starvation, abort, reset and back-to-back.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_d;
  logic              busy;

  logic              rsp_ack = 1'b0;
  logic              inj_ack = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  int                mem_lat = 1;

  int n_total = 0;
  int n_pass  = 0;
  int n_if_ack = 0;
  int n_d_ack  = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } grant_t;
  grant_t grants[$];

  typedef struct {
    bit                is_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                lat;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  assign mem_ack   = rsp_ack | inj_ack;
  assign mem_rdata = mem_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_abort (if_abort),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_if (stall_if),
    .stall_d  (stall_d),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Memory model: acks mem_lat cycles after mem_req is first seen high.
  initial begin
    int age;
    bit done;
    age  = 0;
    done = 0;
    forever begin
      @(posedge clk); #1;
      rsp_ack = 1'b0;
      if (!mem_req) begin
        age  = 0;
        done = 0;
      end else if (!done) begin
        if (age == mem_lat) begin
          rsp_ack = 1'b1;
          done    = 1;
        end else begin
          age++;
        end
      end
    end
  end

  // Grant log, ack counters and per-cycle invariants.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) grants.push_back(grant_t'{mem_we, mem_addr, mem_wdata});
      prev = mem_req;
      if (if_ack) n_if_ack++;
      if (d_ack) n_d_ack++;
      chk("inv_stall_if", stall_if, if_req & ~if_ack);
      chk("inv_stall_d", stall_d, d_req & ~d_ack);
      chk("inv_ack_excl", if_ack & d_ack, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_txn(input vec_t v, input string tag);
    int cyc;
    bit got;
    @(posedge clk); #1;
    mem_data = v.rdata;
    mem_lat  = v.lat;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk({tag, "_req_early"}, mem_req, 0);
    @(negedge clk);
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_mem_we"}, mem_we, v.is_d ? v.we : 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, v.addr);
    if (v.is_d) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    got = 0;
    while (!got && cyc < v.lat + 6) begin
      @(negedge clk);
      cyc++;
      if (v.is_d ? d_ack : if_ack) got = 1;
    end
    chk({tag, "_latency"}, got ? cyc : 0, v.lat + 1);
    if (got) begin
      chk({tag, "_rdata"}, v.is_d ? d_rdata : {32'h0, if_rdata}, v.exp);
      chk({tag, "_other_ack"}, v.is_d ? if_ack : d_ack, 0);
      chk({tag, "_ack_mem_req"}, mem_req, 0);
      chk({tag, "_ack_busy"}, busy, 0);
    end
    @(posedge clk); #1;
    if (v.is_d) d_req = 1'b0;
    else if_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, v.is_d ? d_ack : if_ack, 0);
    chk({tag, "_no_regrant"}, mem_req, 0);
  endtask

  task automatic do_abort(input int k, input string tag);
    int base_if;
    int base_g;
    @(posedge clk); #1;
    base_if  = n_if_ack;
    base_g   = grants.size();
    mem_lat  = 3;
    mem_data = 64'h0BAD_F00D_DEAD_C0DE;
    if_req   = 1'b1;
    if_addr  = 32'h600;
    @(posedge clk); #1;
    repeat (k) begin
      @(posedge clk); #1;
    end
    if_abort = 1'b1;
    if_req   = 1'b0;
    @(posedge clk); #1;
    if_abort = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    @(posedge clk); #1;
    chk({tag, "_if_ack_count"}, n_if_ack - base_if, 0);
    chk({tag, "_grants"}, grants.size() - base_g, 1);
  endtask

  task automatic starve_round(input string tag);
    int cyc;
    bit if_done;
    int base_d;
    int base_if;
    int n_lead;
    bit run;
    @(posedge clk); #1;
    grants.delete();
    base_d  = n_d_ack;
    base_if = n_if_ack;
    mem_lat = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = '0;
    if_req = 1'b1; if_addr = 32'h500;
    cyc = 0;
    if_done = 0;
    while (!if_done && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (if_ack) begin
        if_done = 1;
      end else begin
        @(posedge clk); #1;
        // Fetch side withdraws only during data ack cycles so each data grant sees it waiting.
        if (grants.size() >= 5) begin
          d_req  = 1'b0;
          if_req = 1'b1;
        end else begin
          if_req = ~d_ack;
        end
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk({tag, "_if_done"}, if_done, 1);
    n_lead = 0;
    run = 1;
    for (int i = 0; i < grants.size(); i++) begin
      if (run && grants[i].addr == 32'h400 && !grants[i].we) n_lead++;
      else run = 0;
    end
    chk({tag, "_data_grants"}, n_lead, STARVE_MAX);
    chk({tag, "_total_grants"}, grants.size(), STARVE_MAX + 1);
    chk({tag, "_if_grant_addr"}, grants.size() > STARVE_MAX ? grants[STARVE_MAX].addr : 32'h0, 32'h500);
    chk({tag, "_d_acks"}, n_d_ack - base_d, STARVE_MAX);
    chk({tag, "_if_acks"}, n_if_ack - base_if, 1);
  endtask

  initial begin
    int cyc;
    bit if_done;
    bit d_seen;
    bit d_first;
    bit got;
    int base_d;
    int base_if;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    vecs[0] = vec_t'{1'b0, 1'b0, 32'h0000_0104, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 3, 64'h0000_0000_AAAA_BBBB};
    vecs[1] = vec_t'{1'b0, 1'b0, 32'h0000_0100, 64'h0, 64'h1111_2222_3333_4444, 1, 64'h0000_0000_3333_4444};
    vecs[2] = vec_t'{1'b1, 1'b0, 32'h0000_0208, 64'h0, 64'hDEAD_BEEF_0123_4567, 2, 64'hDEAD_BEEF_0123_4567};
    vecs[3] = vec_t'{1'b1, 1'b1, 32'h0000_0200, 64'h1234, 64'h5555_6666_7777_8888, 0, 64'h5555_6666_7777_8888};
    vecs[4] = vec_t'{1'b0, 1'b0, 32'hFFFF_FFFC, 64'h0, 64'h89AB_CDEF_7654_3210, 2, 64'h0000_0000_89AB_CDEF};
    vecs[5] = vec_t'{1'b1, 1'b0, 32'h0000_0000, 64'h0, 64'h0F0F_1E1E_2D2D_3C3C, 4, 64'h0F0F_1E1E_2D2D_3C3C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous store and fetch: data first, then the fetch exactly once.
    @(posedge clk); #1;
    grants.delete();
    mem_lat  = 1;
    mem_data = 64'hCAFE_0001_9876_5432;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 64'h1234;
    cyc = 0; if_done = 0; d_seen = 0; d_first = 0;
    while (!if_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin
        d_seen  = 1;
        d_first = 1;
      end
      if (if_ack) begin
        if_done = 1;
        chk("sim_if_rdata", if_rdata, 32'h9876_5432);
      end else begin
        @(posedge clk); #1;
        if (d_seen) d_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk("sim_if_done", if_done, 1);
    chk("sim_d_before_if", d_first, 1);
    chk("sim_grants", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("sim_g0_we", grants[0].we, 1);
      chk("sim_g0_addr", grants[0].addr, 32'h200);
      chk("sim_g0_wdata", grants[0].wdata, 64'h1234);
      chk("sim_g1_we", grants[1].we, 0);
      chk("sim_g1_addr", grants[1].addr, 32'h300);
    end

    starve_round("starve0");
    starve_round("starve1");

    do_abort(2, "abort_pre");
    do_txn(vecs[1], "after_abort_pre");
    do_abort(3, "abort_ack");
    do_txn(vecs[0], "after_abort_ack");

    // Reset while a load waits for its memory ack, then a stray late ack.
    @(posedge clk); #1;
    mem_lat = 50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_mem_req", mem_req, 1);
    chk("rstmid_busy", busy, 1);
    @(posedge clk); #1;
    rst   = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_mem_req", mem_req, 0);
    chk("rstmid_after_busy", busy, 0);
    chk("rstmid_after_d_ack", d_ack, 0);
    base_d  = n_d_ack;
    base_if = n_if_ack;
    @(posedge clk); #1;
    inj_ack = 1'b1;
    @(posedge clk); #1;
    inj_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_mem_req", mem_req, 0);
    @(posedge clk); #1;
    chk("late_ack_no_acks", (n_d_ack - base_d) + (n_if_ack - base_if), 0);
    mem_lat = 1;

    // Back-to-back loads with d_req held through the ack cycle.
    @(posedge clk); #1;
    grants.delete();
    mem_lat  = 1;
    mem_data = 64'h1111_1111_1111_1111;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (d_ack) got = 1;
    end
    chk("b2b_first_ack", got, 1);
    chk("b2b_first_rdata", d_rdata, 64'h1111_1111_1111_1111);
    @(posedge clk); #1;
    d_addr   = 32'h808;
    mem_data = 64'h2222_2222_2222_2222;
    @(negedge clk);
    chk("b2b_no_dup_grant", mem_req, 0);
    @(negedge clk);
    chk("b2b_second_req", mem_req, 1);
    chk("b2b_second_addr", mem_addr, 32'h808);
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (d_ack) got = 1;
    end
    chk("b2b_second_ack", got, 1);
    chk("b2b_second_rdata", d_rdata, 64'h2222_2222_2222_2222);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk("b2b_grants", grants.size(), 2);

    do_txn(vecs[2], "final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
